// File: rtl/lvds_capture_pkg.sv
// Shared types and helpers for the LVDS capture sequencer: state encoding,
// frame counter width and the frame-length clamp.
package lvds_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int FRAME_CNT_W = 16;

  // A zero or oversized request means "fill the whole buffer".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
    return (len == 0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/lvds_capture_seq_if.sv
// Write port of the external dual-port capture buffer; the sequencer is the
// master, the buffer (or a monitor) is the slave.
interface lvds_capture_seq_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] wr_addr;
  logic [NUM_CH-1:0] wr_data;
  logic              wr_en;

  modport master (output wr_addr, wr_data, wr_en);
  modport slave  (input  wr_addr, wr_data, wr_en);
endinterface

// File: rtl/lvds_capture_ctr.sv
// Loadable up-counter with a terminal-count flag; used for settle time,
// write address and (optionally) decimation.
module lvds_capture_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + W'(1);
  end

  assign tc = (count == term);

endmodule

// File: rtl/lvds_capture_seq.sv
// LVDS capture sequencer: drives the P12 select switches, waits a settle time,
// then writes frames of LVDS samples into the capture buffer. Optional
// decimation is enabled by defining LVDS_CAPTURE_DECIM_EN.
module lvds_capture_seq
  import lvds_capture_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int DEPTH         = 512,
  parameter  int SETTLE_CYCLES = 8,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic                   LVDS_CLK,
  input  logic                   LVDS_RESETN,
  input  logic [NUM_CH-1:0]      LVDS_IN,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cont,
  input  logic [ADDR_W:0]        len,
`ifdef LVDS_CAPTURE_DECIM_EN
  input  logic [7:0]             decim,
`endif
  lvds_capture_seq_if.master     wr,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   P12_SEL1,
  output logic                   P12_SEL3
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t            state;
  logic              cont_q;
  logic [ADDR_W-1:0] last_addr;
  logic [7:0]        settle_cnt;
  logic              settle_tc;
  logic [ADDR_W-1:0] addr_cnt;
  logic              addr_tc;
  logic              wr_now;
  logic              unused_cnt;

  lvds_capture_ctr #(.W(8)) u_settle (
    .clk(LVDS_CLK), .rst_n(LVDS_RESETN),
    .load(state != ST_SETTLE), .en(1'b1), .load_val('0), .term(SETTLE_LAST),
    .count(settle_cnt), .tc(settle_tc)
  );

  // Held at zero outside CAPTURE so each frame (including continuous
  // re-entry from DONE) starts at address 0.
  lvds_capture_ctr #(.W(ADDR_W)) u_addr (
    .clk(LVDS_CLK), .rst_n(LVDS_RESETN),
    .load(state != ST_CAPTURE), .en(wr_now), .load_val('0), .term(last_addr),
    .count(addr_cnt), .tc(addr_tc)
  );

`ifdef LVDS_CAPTURE_DECIM_EN
  logic [7:0] decim_q;
  logic [7:0] decim_cnt;
  logic       decim_tc;

  // Writes land on the (decim+1)th CAPTURE cycle, then the phase restarts.
  lvds_capture_ctr #(.W(8)) u_decim (
    .clk(LVDS_CLK), .rst_n(LVDS_RESETN),
    .load(state != ST_CAPTURE || decim_tc), .en(1'b1), .load_val('0), .term(decim_q),
    .count(decim_cnt), .tc(decim_tc)
  );

  assign wr_now     = (state == ST_CAPTURE) && decim_tc;
  assign unused_cnt = ^{settle_cnt, decim_cnt};
`else
  assign wr_now     = (state == ST_CAPTURE);
  assign unused_cnt = ^settle_cnt;
`endif

  always_ff @(posedge LVDS_CLK or negedge LVDS_RESETN) begin
    if (!LVDS_RESETN) begin
      state      <= ST_IDLE;
      cont_q     <= 1'b0;
      last_addr  <= '0;
`ifdef LVDS_CAPTURE_DECIM_EN
      decim_q    <= '0;
`endif
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
      wr.wr_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= '0;
      P12_SEL1   <= 1'b0;
      P12_SEL3   <= 1'b0;
    end else begin
      wr.wr_data <= LVDS_IN;
      wr.wr_en   <= 1'b0;
      done       <= 1'b0;
      // Abort outranks every transition, so DONE's pulse and count are skipped.
      if (abort && state != ST_IDLE) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        P12_SEL1 <= 1'b0;
        P12_SEL3 <= 1'b0;
      end else begin
        busy     <= (state != ST_IDLE);
        P12_SEL1 <= (state != ST_IDLE);
        P12_SEL3 <= (state != ST_IDLE);
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              cont_q    <= cont;
              last_addr <= ADDR_W'(eff_len(32'(len), DEPTH) - 1);
`ifdef LVDS_CAPTURE_DECIM_EN
              decim_q   <= decim;
`endif
              frame_cnt <= '0;
              state     <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_tc) state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (wr_now) begin
              wr.wr_en   <= 1'b1;
              wr.wr_addr <= addr_cnt;
              if (addr_tc) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            done      <= 1'b1;
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            state     <= cont_q ? ST_CAPTURE : ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_capture_seq.sv
// Self-checking bench for lvds_capture_seq: random LVDS data, expected write
// stream derived from the frame timing rules by a cycle-indexed model.
module tb_lvds_capture_seq;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 512;
  localparam int SETTLE = 8;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int MEM    = 16384;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] lvds_in;
  logic              start;
  logic              abort;
  logic              cont;
  logic [LEN_W-1:0]  len;
`ifdef LVDS_CAPTURE_DECIM_EN
  logic [7:0]        decim;
`endif
  logic              busy;
  logic              done;
  logic [15:0]       frame_cnt;
  logic              sel1;
  logic              sel3;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  logic [NUM_CH-1:0] in_at [MEM];
  wr_t wr_q[$];
  wr_t exp_w[$];
  wr_t tmp_q[$];
  int  done_q[$];
  int  exp_d[$];

  lvds_capture_seq_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) wr ();

  lvds_capture_seq #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .LVDS_CLK(clk),
    .LVDS_RESETN(rst_n),
    .LVDS_IN(lvds_in),
    .start(start),
    .abort(abort),
    .cont(cont),
    .len(len),
`ifdef LVDS_CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .wr(wr),
    .busy(busy),
    .done(done),
    .frame_cnt(frame_cnt),
    .P12_SEL1(sel1),
    .P12_SEL3(sel3)
  );

  always #5 clk = ~clk;

  // Edge index and the LVDS sample seen at each rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    in_at[(cyc + 1) % MEM] <= lvds_in;
  end

  always @(negedge clk) begin
    if (wr.wr_en === 1'b1) wr_q.push_back('{cyc, int'(wr.wr_addr), int'(wr.wr_data)});
    if (done === 1'b1) done_q.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      lvds_in = NUM_CH'($urandom);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  function automatic int eff_len_of(input int l);
    return (l == 0 || l > DEPTH) ? DEPTH : l;
  endfunction

  // Edge after which the last expected done pulse is visible.
  function automatic int last_done(input int s, input int l, input int d, input int nf);
    return s + SETTLE + nf * (eff_len_of(l) * (d + 1) + 1);
  endfunction

  task automatic do_start(input int l, input bit c, input int d, output int s);
    tick(1);
    wr_q.delete();
    done_q.delete();
    len   = LEN_W'(l);
    cont  = c;
`ifdef LVDS_CAPTURE_DECIM_EN
    decim = 8'(d);
`else
    if (d != 0) $display("decimation requested without LVDS_CAPTURE_DECIM_EN");
`endif
    start = 1'b1;
    s     = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  // Frame f begins capturing right after edge base_f; write j lands (j+1)
  // write periods later, done one edge after the last write.
  task automatic build_exp(input int s, input int l, input int d, input int nf);
    int eff;
    int base;
    int c;
    eff  = eff_len_of(l);
    base = s + SETTLE;
    exp_w.delete();
    exp_d.delete();
    for (int f = 0; f < nf; f++) begin
      for (int j = 0; j < eff; j++) begin
        c = base + (j + 1) * (d + 1);
        exp_w.push_back('{c, j, int'(in_at[c % MEM])});
      end
      base = base + eff * (d + 1) + 1;
      exp_d.push_back(base);
    end
  endtask

  task automatic compare_lists(input string tag);
    check({tag, "_nwrites"}, wr_q.size(), exp_w.size());
    for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++) begin
      check({tag, "_wr_cycle"}, wr_q[i].cyc,  exp_w[i].cyc);
      check({tag, "_wr_addr"},  wr_q[i].addr, exp_w[i].addr);
      check({tag, "_wr_data"},  wr_q[i].data, exp_w[i].data);
    end
    check({tag, "_ndone"}, done_q.size(), exp_d.size());
    for (int i = 0; i < done_q.size() && i < exp_d.size(); i++)
      check({tag, "_done_cycle"}, done_q[i], exp_d[i]);
  endtask

  task automatic check_single(input string tag, input int s, input int l, input int d);
    int ld;
    ld = last_done(s, l, d, 1);
    wait_until(ld + 1);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_sel1_fall"}, sel1, 1'b0);
    check({tag, "_sel3_fall"}, sel3, 1'b0);
    check({tag, "_done_low"},  done, 1'b0);
    check({tag, "_frame_cnt"}, frame_cnt, 16'd1);
    wait_until(ld + 3);
    build_exp(s, l, d, 1);
    compare_lists(tag);
  endtask

  initial begin
    int s;
    int m;
    int l;
    int ld;

    rst_n   = 1'b0;
    lvds_in = '0;
    start   = 1'b0;
    abort   = 1'b0;
    cont    = 1'b0;
    len     = '0;
`ifdef LVDS_CAPTURE_DECIM_EN
    decim   = '0;
`endif

    // Reset state
    tick(3);
    check("rst_wr_en",     wr.wr_en,   1'b0);
    check("rst_wr_addr",   wr.wr_addr, '0);
    check("rst_wr_data",   wr.wr_data, '0);
    check("rst_busy",      busy,       1'b0);
    check("rst_done",      done,       1'b0);
    check("rst_frame_cnt", frame_cnt,  16'd0);
    check("rst_sel1",      sel1,       1'b0);
    check("rst_sel3",      sel3,       1'b0);
    rst_n = 1'b1;
    tick(2);

    // Single shot, len=16: select/busy timing then the write stream
    do_start(16, 1'b0, 0, s);
    wait_until(s + 1);
    check("a_busy_rise", busy, 1'b1);
    check("a_sel1_rise", sel1, 1'b1);
    check("a_sel3_rise", sel3, 1'b1);
    wait_until(s + SETTLE);
    check("a_settle_no_wr", wr.wr_en, 1'b0);
    check_single("a", s, 16, 0);

    // Minimum length
    do_start(1, 1'b0, 0, s);
    check_single("len1", s, 1, 0);

    // len=0 and len>DEPTH both clamp to DEPTH
    do_start(0, 1'b0, 0, s);
    check_single("len0", s, 0, 0);
    do_start(600, 1'b0, 0, s);
    check_single("len600", s, 600, 0);

    // Continuous len=4, abort right after the third done
    do_start(4, 1'b1, 0, s);
    ld = last_done(s, 4, 0, 3);
    wait_until(ld);
    abort = 1'b1;
    m     = cyc + 1;
    tick(1);
    abort = 1'b0;
    tick(1);
    check("c_abort_wr_en", wr.wr_en, 1'b0);
    check("c_abort_busy",  busy,     1'b0);
    check("c_abort_sel1",  sel1,     1'b0);
    check("c_abort_sel3",  sel3,     1'b0);
    wait_until(m + 12);
    check("c_frame_cnt", frame_cnt, 16'd3);
    // A write on the abort edge itself is allowed; nothing may follow it.
    tmp_q.delete();
    foreach (wr_q[i]) if (wr_q[i].cyc != m) tmp_q.push_back(wr_q[i]);
    wr_q = tmp_q;
    build_exp(s, 4, 0, 3);
    compare_lists("cont");

    // start while busy is ignored, including its cont and len
    l = $urandom_range(8, 40);
    do_start(l, 1'b0, 0, s);
    wait_until(s + SETTLE + 5);
    len   = LEN_W'(3);
    cont  = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_single("ign", s, l, 0);

    // Asynchronous reset mid-capture, then a clean restart
    do_start(20, 1'b0, 0, s);
    wait_until(s + SETTLE + 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en",     wr.wr_en,   1'b0);
    check("mid_rst_wr_addr",   wr.wr_addr, '0);
    check("mid_rst_wr_data",   wr.wr_data, '0);
    check("mid_rst_busy",      busy,       1'b0);
    check("mid_rst_done",      done,       1'b0);
    check("mid_rst_frame_cnt", frame_cnt,  16'd0);
    check("mid_rst_sel1",      sel1,       1'b0);
    check("mid_rst_sel3",      sel3,       1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    l = $urandom_range(2, 30);
    do_start(l, 1'b0, 0, s);
    check_single("after_rst", s, l, 0);

`ifdef LVDS_CAPTURE_DECIM_EN
    // Decimation by 3, eight writes
    do_start(8, 1'b0, 2, s);
    check_single("decim", s, 8, 2);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvds_capture_seq.md
# lvds_capture_seq

Parametrised LVDS capture sequencer for the data-read path. It drives the P12 input-select switches and waits a programmable settle time. It then writes a programmable-length frame of NUM_CH-bit LVDS samples into an external dual-port capture buffer, in single-shot or continuous mode, and reports completion. It runs entirely in the LVDS clock domain; control inputs arrive already synchronised from the AXI register block.

## Interface
Parameters:
- NUM_CH, 4, LVDS lanes captured per sample (1..16).
- DEPTH, 512, buffer depth in samples; power of two, 16..4096.
- SETTLE_CYCLES, 8, LVDS_CLK cycles between SEL assertion and first write (1..255).
- ADDR_W, $clog2(DEPTH), derived localparam; not overridable.

Ports:
- Clock and reset (already decided): one clock, LVDS_CLK; asynchronous active-low reset, LVDS_RESETN.
- LVDS_CLK  in  1  capture clock; all logic on its rising edge.
- LVDS_RESETN  in  1  asynchronous reset, active low.
- LVDS_IN  in  NUM_CH  raw lane samples.
- start  in  1  one-cycle pulse; arms capture.
- abort  in  1  level or pulse; forces return to IDLE.
- cont  in  1  1 = continuous frames, 0 = single shot; sampled on start.
- len  in  ADDR_W+1  samples per frame; sampled on start.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  NUM_CH  buffer write data.
- wr_en  out  1  buffer write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of each frame.
- frame_cnt  out  16  completed frames since last start; wraps.
- P12_SEL1, P12_SEL3  out  1  input-select switch controls.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE: SELs low, wr_en low. Start is acted on only in IDLE. On start, latch cont and len into registers and clear frame_cnt. Go to SETTLE.
- SETTLE: SELs high, settle counter runs 0..SETTLE_CYCLES-1, then go to CAPTURE.
- CAPTURE: SELs high, wr_en high every cycle. wr_addr counts from 0 upward; wr_data is LVDS_IN delayed by one input register. After the write at address eff_len-1, go to DONE.
- eff_len: len==0 or len>DEPTH → DEPTH; otherwise len.
- DONE (one cycle): done=1 and frame_cnt increments. If latched cont=1, go to CAPTURE with wr_addr=0, with no re-settle and SELs staying high. Otherwise go to IDLE.
- abort while not IDLE: next state IDLE. No done pulse. No frame_cnt increment. Buffer contents partial. Abort has priority over all transitions, including a same-cycle start.
- start while busy: ignored; latched cont/len unchanged.
- frame_cnt wraps 0xFFFF→0x0000 silently.

## Timing
- Reset values: wr_addr=0, wr_data=0, wr_en=0, busy=0, done=0, frame_cnt=0, P12_SEL1=P12_SEL3=0, state IDLE.
- All outputs are registered.
- start at edge N: busy and SELs high after edge N+1. First wr_en after edge N+1+SETTLE_CYCLES.
- Sample written at address k equals LVDS_IN present one cycle before the wr_en cycle that carries address k.
- Single frame: exactly eff_len wr_en cycles. done follows the last write by one cycle. busy falls the cycle after done.
- Continuous: between frames, one cycle with wr_en=0 (the DONE cycle).
- Abort sampled at edge M: wr_en, busy and SELs are low after edge M+1.
- Asynchronous reset mid-frame: all outputs go to reset values immediately. Buffer contents are not cleared.

## Configuration
- LVDS_CAPTURE_DECIM_EN defined:
  - Adds input port decim [7:0], sampled on start.
  - In CAPTURE, write only every (decim+1)th cycle; wr_en low on the skipped cycles.
  - wr_data is the most recent sample. wr_addr advances only on writes.
  - Frame length is still eff_len writes.
- Macro undefined: port absent; every CAPTURE cycle writes (equivalent to decim=0).

## Structure
- Shared package lvds_capture_pkg holds:
  - state encoding localparams ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE;
  - FRAME_CNT_W=16;
  - the eff_len clamp function.
- One sub-module, lvds_capture_ctr: loadable up-counter with terminal-count flag. Instantiated for the settle counter, the address counter and, under the macro, the decimation counter.

## Test plan
- Single shot, NUM_CH=4, DEPTH=512, len=16, SETTLE=8, LVDS_IN incrementing pattern → first wr_en 9 cycles after start; addresses 0..15 with wr_data = prior-cycle input; done on cycle 26; busy low on cycle 27; frame_cnt=1.
- len=0, then len=600 → both frames write 512 samples; addresses 0..511; one done pulse each.
- Continuous, len=4 → pattern of 4 writes then one idle cycle; done every 5 cycles; abort after 3 frames → frame_cnt=3, no 4th done, SELs low 1 cycle after abort.
- start pulsed during CAPTURE with different len → ignored; frame length unchanged.
- LVDS_RESETN asserted mid-CAPTURE → all outputs 0 immediately; after release, the next start runs normally from address 0.
- With LVDS_CAPTURE_DECIM_EN, decim=2, len=8 → wr_en every 3rd cycle; 8 writes over 24 CAPTURE cycles; addresses 0..7.
